// File: rtl/apb_i2c_cmd_sequencer.sv
// APB master that drains a small (I2C address, byte) command FIFO into the APB-to-I2C bridge,
// retrying NACKed transfers, aborting on ACCESS timeout and spacing transfers by an idle gap.
module apb_i2c_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned GAP_CYC     = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [6:0]                  cmd_addr,
    input  logic [7:0]                  cmd_data,
    output logic                        PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [6:0]                  PADDR,
    output logic [7:0]                  PWDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [1:0]                  err_code,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;

    state_t          state, state_nxt;
    cmd_t            mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_nxt;
    logic [TW-1:0]   tcnt;
    logic [GW-1:0]   gcnt;
    logic [RW-1:0]   retry_cnt;
    logic            retry_pend;
    logic            push, pop;
    logic            xfer_ok, xfer_retry, nack_fail, timeout;

    assign push = cmd_valid && cmd_ready;

    // Occupancy after this edge; simultaneous push and pop leave it unchanged
    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop) begin
            count_nxt = fifo_count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = fifo_count - CW'(1);
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-transfer outcome strobes; PREADY outranks the timeout
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        xfer_ok    = 1'b0;
        xfer_retry = 1'b0;
        nack_fail  = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_nxt = GAP;
                    if (!PSLVERR) begin
                        xfer_ok = 1'b1;
                    end else if (retry_cnt < RW'(MAX_RETRY)) begin
                        xfer_retry = 1'b1;
                    end else begin
                        nack_fail = 1'b1;
                    end
                end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gcnt == GW'(GAP_CYC - 1)) begin
                    state_nxt = retry_pend ? SETUP : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr] <= cmd_t'({cmd_addr, cmd_data});
        end
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmd_ready  <= 1'b1;
            PADDR      <= '0;
            PWDATA     <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            tcnt       <= '0;
            gcnt       <= '0;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            fifo_count <= count_nxt;
            cmd_ready  <= count_nxt < CW'(FIFO_DEPTH);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                PADDR     <= mem[rd_ptr].addr;
                PWDATA    <= mem[rd_ptr].data;
                retry_cnt <= '0;
            end
            tcnt <= (state == ACCESS && state_nxt == ACCESS) ? tcnt + TW'(1) : '0;
            gcnt <= (state == GAP && state_nxt == GAP) ? gcnt + GW'(1) : '0;
            if (xfer_retry) begin
                retry_cnt  <= retry_cnt + RW'(1);
                retry_pend <= 1'b1;
            end else if (state == GAP && state_nxt == SETUP) begin
                retry_pend <= 1'b0;
            end
            PSEL    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            PWRITE  <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            PENABLE <= (state_nxt == ACCESS);
            busy    <= (state_nxt != IDLE) || (count_nxt != '0);
            done    <= xfer_ok;
            err     <= nack_fail || timeout;
            if (nack_fail) begin
                err_code <= 2'b01;
            end else if (timeout) begin
                err_code <= 2'b10;
            end
        end
    end

endmodule
